// File: rtl/cmp_search_pkg.sv
// Shared types for the comparator-driven binary search: FSM states and the
// one-hot encodings of the comparator flag vector {less, equal, greater}.
package cmp_search_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PROBE  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [2:0] FLAG_LESS    = 3'b100;
    localparam logic [2:0] FLAG_EQUAL   = 3'b010;
    localparam logic [2:0] FLAG_GREATER = 3'b001;

endpackage

// File: rtl/cmp_search_mid.sv
// Midpoint of the live search window, lo + (hi - lo)/2, evaluated one bit wider
// than the operands so the subtraction and sum can never wrap.
module cmp_search_mid #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] mid
);

    // Only meaningful when lo <= hi; the caller flags an empty window before using mid.
    assign mid = WIDTH'({1'b0, lo} + (({1'b0, hi} - {1'b0, lo}) >> 1));

endmodule

// File: rtl/cmp_search.sv
// Binary search of an unknown target using an external comparator (guess vs target).
// Optional probe limit: define CMP_SEARCH_TIMEOUT_EN to abort after WIDTH+1 probes.
module cmp_search
    import cmp_search_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        start,
    output logic [WIDTH-1:0]            guess,
    input  logic                        less,
    input  logic                        equal,
    input  logic                        greater,
    output logic                        busy,
    output logic                        done,
    output logic                        found,
    output logic [WIDTH-1:0]            result,
    output logic [$clog2(WIDTH+2)-1:0]  steps,
    output logic                        err
);

    localparam int SW = $clog2(WIDTH+2);
    localparam logic [WIDTH-1:0] GUESS_MAX  = '1;
    localparam logic [WIDTH-1:0] GUESS_INIT = WIDTH'((1 << (WIDTH-1)) - 1);
    localparam logic [SW-1:0]    STEPS_MAX  = '1;

    state_e            state_q;
    logic [WIDTH-1:0]  lo_q, hi_q, guess_q, result_q, mid;
    logic [SW-1:0]     steps_q, steps_d;
    logic              busy_q, done_q, found_q, err_q;
    logic [2:0]        flags;
    logic              timeout;

    cmp_search_mid #(.WIDTH(WIDTH)) u_mid (
        .lo  (lo_q),
        .hi  (hi_q),
        .mid (mid)
    );

    assign flags   = {less, equal, greater};
    assign steps_d = (steps_q == STEPS_MAX) ? steps_q : steps_q + 1'b1;

`ifdef CMP_SEARCH_TIMEOUT_EN
    localparam logic [SW-1:0] STEPS_LIMIT = SW'(WIDTH + 1);
    assign timeout = (steps_q >= STEPS_LIMIT);
`else
    assign timeout = 1'b0;
`endif

    // NOTE: every state register uses <= so all updates see pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            lo_q     <= '0;
            hi_q     <= '1;
            guess_q  <= '0;
            result_q <= '0;
            steps_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        lo_q     <= '0;
                        hi_q     <= '1;
                        guess_q  <= GUESS_INIT;
                        steps_q  <= '0;
                        found_q  <= 1'b0;
                        err_q    <= 1'b0;
                        result_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_PROBE;
                    end
                end
                ST_PROBE: begin
                    if (timeout) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        steps_q <= steps_d;
                        case (flags)
                            FLAG_EQUAL: begin
                                found_q  <= 1'b1;
                                result_q <= guess_q;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                state_q  <= ST_DONE;
                            end
                            FLAG_LESS: begin
                                if (guess_q == GUESS_MAX) begin
                                    err_q   <= 1'b1;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= ST_DONE;
                                end else begin
                                    lo_q    <= guess_q + 1'b1;
                                    state_q <= ST_UPDATE;
                                end
                            end
                            FLAG_GREATER: begin
                                if (guess_q == '0) begin
                                    err_q   <= 1'b1;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= ST_DONE;
                                end else begin
                                    hi_q    <= guess_q - 1'b1;
                                    state_q <= ST_UPDATE;
                                end
                            end
                            default: begin
                                err_q   <= 1'b1;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_UPDATE: begin
                    if (lo_q > hi_q) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        guess_q <= mid;
                        state_q <= ST_PROBE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign guess  = guess_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign found  = found_q;
    assign result = result_q;
    assign steps  = steps_q;
    assign err    = err_q;

endmodule

// File: tb/tb_cmp_search.sv
// Directed bench for cmp_search (WIDTH=4) with a behavioural comparator against a
// fixed target; expected probe values are queued before each search and popped per probe.
module tb_cmp_search;

    localparam int WIDTH = 4;

    logic             sys_clk;
    logic             sys_rst_n;
    logic             start;
    logic [WIDTH-1:0] guess;
    logic             less, equal, greater;
    logic             busy, done, found, err;
    logic [WIDTH-1:0] result;
    logic [2:0]       steps;

    int tgt;
    int mode;   // 0: real comparator, 1: flags all zero, 2: always less
    int total;
    int bad;
    int exp_q[$];

    cmp_search #(.WIDTH(WIDTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .guess     (guess),
        .less      (less),
        .equal     (equal),
        .greater   (greater),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .result    (result),
        .steps     (steps),
        .err       (err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always_comb begin
        less    = 1'b0;
        equal   = 1'b0;
        greater = 1'b0;
        case (mode)
            0: begin
                less    = (int'(guess) < tgt);
                equal   = (int'(guess) == tgt);
                greater = (int'(guess) > tgt);
            end
            2: less = 1'b1;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full search; exp_q must already hold the expected probe sequence.
    task automatic run(input int t, input int m, input logic ef, input int er,
                       input int es, input logic ee, input int elat, input bit poke);
        int  n;
        bit  seen;
        int  g;
        tgt   = t;
        mode  = m;
        start = 1'b1;
        n     = 0;
        seen  = 1'b0;
        while (!seen && n < 40) begin
            @(negedge sys_clk);
            start = 1'b0;
            n++;
            if (done) begin
                seen = 1'b1;
                check("latency", n, elat);
                check("busy_in_done", busy, 0);
                check("found", found, ef);
                check("result", result, er);
                check("steps", steps, es);
                check("err", err, ee);
            end else begin
                check("busy_in_search", busy, 1);
                if (n % 2 == 1) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $error("FAIL extra_probe: observed guess=%0d expected none", guess);
                    end else begin
                        g = exp_q.pop_front();
                        check("guess", guess, g);
                    end
                end
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $error("FAIL done_timeout: observed no done in %0d cycles expected done", n);
        end
        check("probes_left", exp_q.size(), 0);
        exp_q.delete();
        if (poke) start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        @(negedge sys_clk);
        check("start_in_done_ignored", busy, 0);
        check("found_held", found, ef);
        check("result_held", result, er);
        check("err_held", err, ee);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        tgt       = 0;
        mode      = 0;
        start     = 1'b0;
        sys_rst_n = 1'b0;
        #2;
        check("rst_guess", guess, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_result", result, 0);
        check("rst_steps", steps, 0);
        check("rst_err", err, 0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // target 11: two probes, start held during DONE must be ignored
        exp_q = '{7, 11};
        run(11, 0, 1'b1, 11, 2, 1'b0, 4, 1'b1);
        check("guess_held_idle", guess, 11);

        exp_q = '{7, 3, 1, 0};
        run(0, 0, 1'b1, 0, 4, 1'b0, 8, 1'b0);

        exp_q = '{7, 11, 13, 14, 15};
        run(15, 0, 1'b1, 15, 5, 1'b0, 10, 1'b0);

        exp_q = '{5, 6};
        exp_q.delete();
        exp_q = '{7};
        run(3, 1, 1'b0, 0, 1, 1'b1, 2, 1'b0);

        exp_q = '{7, 11, 13, 14, 15};
        run(0, 2, 1'b0, 0, 5, 1'b1, 10, 1'b0);

        // second always-less run, reset asserted mid-search
        mode  = 2;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (4) @(negedge sys_clk);
        check("mid_busy", busy, 1);
        #1 sys_rst_n = 1'b0;
        #1;
        check("mrst_guess", guess, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_found", found, 0);
        check("mrst_result", result, 0);
        check("mrst_steps", steps, 0);
        check("mrst_err", err, 0);
        repeat (2) begin
            @(negedge sys_clk);
            check("mrst_no_done", done, 0);
        end
        sys_rst_n = 1'b1;
        repeat (3) begin
            @(negedge sys_clk);
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
            check("post_rst_steps", steps, 0);
        end

        // fresh search after reset still works
        mode  = 0;
        exp_q = '{7, 3, 5};
        run(5, 0, 1'b1, 5, 3, 1'b0, 6, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
